// File: rtl/sram_req_port_if.sv
// Signal bundle for sram_req_port: engine request stream, read response stream and SRAM macro pins.
// slave is the controller's view; master is the engine/SRAM side.
interface sram_req_port_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128,
  parameter int BE_WIDTH   = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic                  ram_ceb;
  logic                  ram_web;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [BE_WIDTH-1:0]   ram_bweb;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready, ram_q,
    output req_ready, rsp_valid, rsp_rdata, ram_ceb, ram_web, ram_a, ram_d, ram_bweb
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready, ram_q,
    input  req_ready, rsp_valid, rsp_rdata, ram_ceb, ram_web, ram_a, ram_d, ram_bweb
  );
endinterface

// File: rtl/sram_req_port.sv
// Request-side controller for a single-port byte-maskable SRAM: registered active-low command,
// two-stage read tracking and an in-order response FIFO guarded by read credits.
module sram_req_port #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128,
  parameter int BE_WIDTH   = 16,
  parameter int RSP_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sram_req_port_if.slave  bus
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic                  req_ready;
  logic                  accept;
  logic                  rd_accept;
  logic                  push;
  logic                  pop;
  logic                  rsp_valid;

  logic [CW-1:0]         outst_q, outst_d;
  logic                  rd_s1_q, rd_s2_q;

  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  ceb_q, ceb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [BE_WIDTH-1:0]   bweb_q, bweb_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Credits count reads from acceptance until their response is popped.
  assign req_ready = (outst_q < DEPTH_C);
  assign accept    = bus.req_valid & req_ready;
  assign rd_accept = accept & ~bus.req_wr;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & bus.rsp_ready;
  assign push      = rd_s2_q;

  always_comb begin
    outst_d = outst_q;
    if (rd_accept && !pop) begin
      outst_d = outst_q + 1'b1;
    end else if (!rd_accept && pop) begin
      outst_d = outst_q - 1'b1;
    end
  end

  always_comb begin
    ceb_d  = ~accept;
    web_d  = ~(accept & bus.req_wr);
    a_d    = a_q;
    wd_d   = wd_q;
    bweb_d = bweb_q;
    if (accept) begin
      a_d    = bus.req_addr;
      bweb_d = bus.req_wr ? ~bus.req_be : '1;
      if (bus.req_wr) begin
        wd_d = bus.req_wdata;
      end
    end
  end

  always_comb begin
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    // Head register looks ahead to the next head; bypass ram_q when that slot is being filled now.
    rdata_d = rdata_q;
    if (count_d != '0) begin
      rdata_d = (push && (wptr_q == rptr_d)) ? bus.ram_q : fifo_q[rptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= '0;
      rd_s1_q <= 1'b0;
      rd_s2_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      outst_q <= outst_d;
      rd_s1_q <= rd_accept;
      rd_s2_q <= rd_s1_q;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wptr_q] <= bus.ram_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ceb_q  <= 1'b1;
      web_q  <= 1'b1;
      a_q    <= '0;
      wd_q   <= '0;
      bweb_q <= '1;
    end else begin
      ceb_q  <= ceb_d;
      web_q  <= web_d;
      a_q    <= a_d;
      wd_q   <= wd_d;
      bweb_q <= bweb_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.ram_ceb   = ceb_q;
  assign bus.ram_web   = web_q;
  assign bus.ram_a     = a_q;
  assign bus.ram_d     = wd_q;
  assign bus.ram_bweb  = bweb_q;
endmodule
